// File: rtl/lsu_ctrl.sv
// Load/store unit: turns a core load/store into one handshaked memory access.
// Builds byte lanes, extends load data, and reports misaligned/illegal/timeout faults.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [2:0]              funct3,
  input  logic [ADDR_WIDTH-1:0]   Addr,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    Stall,
  output logic                    Done,
  output logic [DATA_WIDTH-1:0]   RDOut,
  output logic                    Fault,
  output logic [1:0]              FaultCode,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: mem_req is held while in REQ; the access is accepted on the
  // first rising edge where mem_req && mem_ready. Load data is taken on the
  // first edge in WAIT where mem_rvalid is high; both are ignored elsewhere.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    fault_q, fault_d;
  logic [1:0]              code_q, code_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NB-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [OW-1:0]           off_q, off_d;

  logic                    req_any;
  logic                    legal;
  logic                    misaligned;
  logic [OW-1:0]           off_in;
  logic [NB-1:0]           be_base;
  logic [NB-1:0]           be_new;
  logic [DATA_WIDTH-1:0]   wdata_new;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Request decode: legality, alignment and lane pattern from funct3/Addr.
  always_comb begin
    req_any    = MemRead | MemWrite;
    off_in     = Addr[OW-1:0];
    legal      = 1'b0;
    misaligned = 1'b0;
    be_base    = '0;
    wdata_new  = WriteData;
    if (MemWrite) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              ((DATA_WIDTH == 64) && (funct3 == 3'b011));
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101) ||
              ((DATA_WIDTH == 64) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
    end
    case (funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        be_base    = NB'(1);
        wdata_new  = {NB{WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = Addr[0];
        be_base    = NB'(3);
        wdata_new  = {(NB/2){WriteData[15:0]}};
      end
      2'b10: begin
        misaligned = |Addr[1:0];
        be_base    = NB'(15);
        wdata_new  = {(NB/4){WriteData[31:0]}};
      end
      default: begin
        misaligned = |Addr[2:0];
        be_base    = '1;
        wdata_new  = WriteData;
      end
    endcase
    be_new = be_base << off_in;
  end

  // Load extraction works on the latched lane offset and width code.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = DATA_WIDTH'($signed(shifted[7:0]));
      3'b001:  load_ext = DATA_WIDTH'($signed(shifted[15:0]));
      3'b010:  load_ext = DATA_WIDTH'($signed(shifted[31:0]));
      3'b100:  load_ext = DATA_WIDTH'(shifted[7:0]);
      3'b101:  load_ext = DATA_WIDTH'(shifted[15:0]);
      3'b110:  load_ext = DATA_WIDTH'(shifted[31:0]);
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fault_d = 1'b0;
    code_d  = 2'b00;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (!legal) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            code_d  = 2'b11;
          end else if (misaligned) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            addr_d  = Addr & ~ADDR_WIDTH'(NB - 1);
            be_d    = be_new;
            wdata_d = wdata_new;
            we_d    = MemWrite;
            f3_d    = funct3;
            off_d   = off_in;
          end
        end
      end
      S_REQ: begin
        cnt_d = CW'(cnt_q + 1'b1);
        if (mem_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end
      end
      S_WAIT: begin
        cnt_d = CW'(cnt_q + 1'b1);
        if (mem_rvalid) begin
          rd_d    = load_ext;
          state_d = S_DONE;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign Stall     = ((state_q == S_IDLE) && req_any) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign Done      = (state_q == S_DONE);
  assign Fault     = fault_q;
  assign FaultCode = code_q;
  assign RDOut     = rd_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: 32-bit and 64-bit instances, directed accesses, scoreboarded
// memory requests and Done responses.
module tb_lsu_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
  } req_t;

  typedef struct packed {
    logic        fault;
    logic [1:0]  code;
    logic [63:0] rd;
  } rsp_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance signals
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] Addr = '0, WriteData = '0;
  logic        Stall, Done, Fault, mem_req, mem_we;
  logic [31:0] RDOut, mem_addr, mem_wdata;
  logic [1:0]  FaultCode, dbg_state;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  // 64-bit instance signals
  logic        MemRead64 = 1'b0, MemWrite64 = 1'b0;
  logic [2:0]  funct3_64 = 3'b000;
  logic [31:0] Addr64 = '0;
  logic [63:0] WriteData64 = '0;
  logic        Stall64, Done64, Fault64, mem_req64, mem_we64;
  logic [63:0] RDOut64, mem_wdata64;
  logic [31:0] mem_addr64;
  logic [1:0]  FaultCode64, dbg_state64;
  logic [7:0]  mem_be64;
  logic        mem_ready64 = 1'b1, mem_rvalid64 = 1'b1;
  logic [63:0] mem_rdata64 = '0;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) u_dut (
    .CLK(clk), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .Done(Done), .RDOut(RDOut),
    .Fault(Fault), .FaultCode(FaultCode), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(16)) u_dut64 (
    .CLK(clk), .RST(RST), .MemRead(MemRead64), .MemWrite(MemWrite64), .funct3(funct3_64),
    .Addr(Addr64), .WriteData(WriteData64), .Stall(Stall64), .Done(Done64), .RDOut(RDOut64),
    .Fault(Fault64), .FaultCode(FaultCode64), .mem_req(mem_req64), .mem_we(mem_we64),
    .mem_addr(mem_addr64), .mem_be(mem_be64), .mem_wdata(mem_wdata64), .mem_ready(mem_ready64),
    .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64), .dbg_state(dbg_state64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t req64_q[$];
  rsp_t rsp64_q[$];

  task automatic exp_req(input logic [31:0] a, input logic [7:0] be, input logic we, input logic [63:0] wd);
    req_q.push_back('{addr: a, be: be, we: we, wdata: wd});
  endtask
  task automatic exp_rsp(input logic f, input logic [1:0] c, input logic [63:0] rd);
    rsp_q.push_back('{fault: f, code: c, rd: rd});
  endtask

  // Memory responder for the 32-bit instance
  int rdy_dly = 0;
  int rv_dly = -1;
  logic force_rv = 1'b0;
  int rcnt = 0;
  int wcnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ready = (rdy_dly >= 0) && (rcnt >= rdy_dly);
      rcnt++;
    end else begin
      mem_ready = 1'b0;
      rcnt = 0;
    end
    if (dbg_state == ST_WAIT) begin
      mem_rvalid = (rv_dly >= 0) && (wcnt >= rv_dly);
      wcnt++;
    end else begin
      mem_rvalid = force_rv;
      wcnt = 0;
    end
  end

  // Monitors: a new request is checked on the first REQ cycle; responses on Done.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    req_t r;
    if (mem_req && !req_prev) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got request addr %h with none expected", mem_addr);
      end else begin
        r = req_q.pop_front();
        check("req_addr", 64'(mem_addr), 64'(r.addr));
        check("req_be", 64'(mem_be), 64'(r.be[3:0]));
        check("req_we", 64'(mem_we), 64'(r.we));
        if (r.we) check("req_wdata", 64'(mem_wdata), r.wdata);
      end
    end
    req_prev = mem_req;
  end

  always @(negedge clk) begin
    rsp_t e;
    if (Done) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got Done with none expected");
      end else begin
        e = rsp_q.pop_front();
        check("rsp_fault", 64'(Fault), 64'(e.fault));
        check("rsp_code", 64'(FaultCode), 64'(e.code));
        check("rsp_rdout", 64'(RDOut), e.rd);
      end
    end
  end

  logic req64_prev = 1'b0;
  always @(negedge clk) begin
    req_t r;
    rsp_t e;
    if (mem_req64 && !req64_prev) begin
      if (req64_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req64: got request addr %h with none expected", mem_addr64);
      end else begin
        r = req64_q.pop_front();
        check("req64_addr", 64'(mem_addr64), 64'(r.addr));
        check("req64_be", 64'(mem_be64), 64'(r.be));
        check("req64_we", 64'(mem_we64), 64'(r.we));
        if (r.we) check("req64_wdata", mem_wdata64, r.wdata);
      end
    end
    req64_prev = mem_req64;
    if (Done64) begin
      if (rsp64_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done64: got Done with none expected");
      end else begin
        e = rsp64_q.pop_front();
        check("rsp64_fault", 64'(Fault64), 64'(e.fault));
        check("rsp64_code", 64'(FaultCode64), 64'(e.code));
        check("rsp64_rdout", RDOut64, e.rd);
      end
    end
  end

  // Driver for the 32-bit instance; reports cycles to Done, stall cycles, request cycles.
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdy, input int rv,
                        input logic [31:0] rdata, output int cyc, output int stl, output int nreq);
    @(posedge clk); #1;
    MemRead = !wr; MemWrite = wr; funct3 = f3; Addr = a; WriteData = wd;
    rdy_dly = rdy; rv_dly = rv; mem_rdata = rdata;
    cyc = 0; stl = 0; nreq = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (Stall) stl++;
      if (mem_req) nreq++;
      if (Done) break;
    end
    if (!Done) begin
      checks++; errors++;
      $display("FAIL done_bound: got no Done in %0d cycles, required Done", cyc);
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic access64(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, input logic [63:0] rdata);
    int n;
    @(posedge clk); #1;
    MemRead64 = !wr; MemWrite64 = wr; funct3_64 = f3; Addr64 = a; WriteData64 = wd;
    mem_rdata64 = rdata;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (Done64) break;
    end
    if (!Done64) begin
      checks++; errors++;
      $display("FAIL done64_bound: got no Done in %0d cycles, required Done", n);
    end
    @(posedge clk); #1;
    MemRead64 = 1'b0; MemWrite64 = 1'b0;
  endtask

  initial begin
    int cyc, stl, nreq;
    logic [31:0] last_rd;
    last_rd = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_fault", 64'(Fault), 64'd0);
    check("rst_code", 64'(FaultCode), 64'd0);
    check("rst_rdout", 64'(RDOut), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_be", 64'(mem_be), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    @(posedge clk); #1;
    RST = 1'b0;

    // sw with immediate ready: Done in cycle 3, stalled for cycles 1-2
    exp_req(32'h104, 8'hF, 1'b1, 64'hDEADBEEF);
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, -1, '0, cyc, stl, nreq);
    check("sw_latency", 64'(cyc), 64'd3);
    check("sw_stall_cycles", 64'(stl), 64'd2);

    // lb / lbu at lane 3, data after 3 idle WAIT cycles
    exp_req(32'h200, 8'h8, 1'b0, '0);
    last_rd = 32'hFFFF_FF80;
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b0, 3'b000, 32'h203, '0, 0, 3, 32'h80FF_1234, cyc, stl, nreq);
    check("lb_latency", 64'(cyc), 64'd7);
    exp_req(32'h200, 8'h8, 1'b0, '0);
    last_rd = 32'h0000_0080;
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b0, 3'b100, 32'h203, '0, 0, 3, 32'h80FF_1234, cyc, stl, nreq);

    // sh at lane 2, then misaligned lh
    exp_req(32'h10, 8'hC, 1'b1, 64'hABCD_ABCD);
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b1, 3'b001, 32'h12, 32'h0000_ABCD, 1, -1, '0, cyc, stl, nreq);
    exp_rsp(1'b1, 2'b01, 64'(last_rd));
    access(1'b0, 3'b001, 32'h13, '0, 0, 0, '0, cyc, stl, nreq);
    check("mis_no_req", 64'(nreq), 64'd0);
    check("mis_latency", 64'(cyc), 64'd2);

    // timeout with ready held low: 16 REQ cycles, RDOut unchanged
    exp_req(32'h40, 8'hF, 1'b0, '0);
    exp_rsp(1'b1, 2'b10, 64'(last_rd));
    access(1'b0, 3'b010, 32'h40, '0, -1, -1, 32'h1234_5678, cyc, stl, nreq);
    check("to_req_cycles", 64'(nreq), 64'd16);
    check("to_latency", 64'(cyc), 64'd18);

    // illegal funct3: ld at 32 bits, sd at 32 bits misaligned, store funct3=100
    exp_rsp(1'b1, 2'b11, 64'(last_rd));
    access(1'b0, 3'b011, 32'h80, '0, 0, 0, '0, cyc, stl, nreq);
    check("ill_no_req", 64'(nreq), 64'd0);
    exp_rsp(1'b1, 2'b11, 64'(last_rd));
    access(1'b1, 3'b011, 32'h81, 32'h1, 0, 0, '0, cyc, stl, nreq);
    exp_rsp(1'b1, 2'b11, 64'(last_rd));
    access(1'b1, 3'b100, 32'h80, 32'h1, 0, 0, '0, cyc, stl, nreq);

    // more lanes and extensions
    exp_req(32'h300, 8'hC, 1'b0, '0);
    last_rd = 32'hFFFF_8001;
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b0, 3'b001, 32'h302, '0, 2, 0, 32'h8001_1234, cyc, stl, nreq);
    exp_req(32'h200, 8'hC, 1'b0, '0);
    last_rd = 32'h0000_8001;
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b0, 3'b101, 32'h202, '0, 0, 1, 32'h8001_1234, cyc, stl, nreq);
    exp_req(32'h4, 8'h8, 1'b1, 64'h5555_5555);
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b1, 3'b000, 32'h7, 32'h1234_5655, 0, -1, '0, cyc, stl, nreq);
    exp_req(32'h300, 8'hF, 1'b0, '0);
    last_rd = 32'h8000_0001;
    exp_rsp(1'b0, 2'b00, 64'(last_rd));
    access(1'b0, 3'b010, 32'h300, '0, 0, 0, 32'h8000_0001, cyc, stl, nreq);
    check("lw_min_latency", 64'(cyc), 64'd4);
    exp_rsp(1'b1, 2'b01, 64'(last_rd));
    access(1'b1, 3'b010, 32'h102, 32'h1, 0, 0, '0, cyc, stl, nreq);

    // reset during the second WAIT cycle, late rvalid afterwards
    exp_req(32'h100, 8'hF, 1'b0, '0);
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; Addr = 32'h100; rdy_dly = 0; rv_dly = -1;
    mem_rdata = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    RST = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    RST = 1'b0; force_rv = 1'b1;
    @(negedge clk);
    check("abort_req", 64'(mem_req), 64'd0);
    check("abort_stall", 64'(Stall), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_rdout", 64'(RDOut), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    force_rv = 1'b0;
    @(negedge clk);
    check("late_rv_done", 64'(Done), 64'd0);
    check("late_rv_rdout", 64'(RDOut), 64'd0);
    check("late_rv_state", 64'(dbg_state), 64'(ST_IDLE));

    // 64-bit instance
    req64_q.push_back('{addr: 32'h08, be: 8'hFF, we: 1'b1, wdata: 64'h1122_3344_5566_7788});
    rsp64_q.push_back('{fault: 1'b0, code: 2'b00, rd: 64'h0});
    access64(1'b1, 3'b011, 32'h08, 64'h1122_3344_5566_7788, '0);
    req64_q.push_back('{addr: 32'h08, be: 8'hF0, we: 1'b0, wdata: '0});
    rsp64_q.push_back('{fault: 1'b0, code: 2'b00, rd: 64'h0000_0000_F000_0001});
    access64(1'b0, 3'b110, 32'h0C, '0, 64'hF000_0001_0000_0000);
    req64_q.push_back('{addr: 32'h08, be: 8'hF0, we: 1'b0, wdata: '0});
    rsp64_q.push_back('{fault: 1'b0, code: 2'b00, rd: 64'hFFFF_FFFF_F000_0001});
    access64(1'b0, 3'b010, 32'h0C, '0, 64'hF000_0001_0000_0000);
    rsp64_q.push_back('{fault: 1'b1, code: 2'b01, rd: 64'hFFFF_FFFF_F000_0001});
    access64(1'b0, 3'b011, 32'h0B, '0, '0);

    repeat (3) @(posedge clk);
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check("req64_q_empty", 64'(req64_q.size()), 64'd0);
    check("rsp64_q_empty", 64'(rsp64_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time: simulation did not finish in bound");
    $fatal(1, "time limit");
  end

endmodule
